// File: rtl/phase_search_ctrl.sv
// Automatic RX sampling-phase search: sweeps every phase, counts I+Q symbol errors per window,
// applies the best phase and flags lock. Optional macro PHASE_SEARCH_TRACK_EN adds in-lock tracking.
//
// state     | meaning
// S_IDLE    | waiting for first i_start
// S_SETTLE  | discarding SETTLE_SYM symbols after a phase change
// S_MEASURE | accumulating errors over WIN_LEN symbols
// S_COMPARE | keep best phase, step to next phase or finish
// S_APPLY   | drive best phase and result outputs, pulse done
// S_LOCKED  | holding result (tracking windows when enabled)
module phase_search_ctrl #(
  parameter int NB_PHASE     = 2,
  parameter int NB_ERR       = 16,
  parameter int WIN_LEN      = 1024,
  parameter int SETTLE_SYM   = 16,
  parameter int LOCK_MAX_ERR = 0
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic                i_errI,
  input  logic                i_errQ,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_busy,
  output logic                o_lock,
  output logic                o_done,
  output logic [NB_ERR-1:0]   o_best_err
);

  localparam int CNT_MAX = (WIN_LEN > SETTLE_SYM) ? WIN_LEN : SETTLE_SYM;
  localparam int NB_CNT  = $clog2(CNT_MAX + 1);
  localparam int NB_SUM  = NB_ERR + 1;
  localparam logic [NB_CNT-1:0]   CNT_WIN    = NB_CNT'(WIN_LEN);
  localparam logic [NB_CNT-1:0]   CNT_SETTLE = NB_CNT'(SETTLE_SYM);
  localparam logic [NB_CNT-1:0]   CNT_ONE    = NB_CNT'(1);
  localparam logic [NB_ERR-1:0]   ERR_MAX    = '1;
  localparam logic [NB_ERR-1:0]   LOCK_THR   = NB_ERR'(LOCK_MAX_ERR);
  localparam logic [NB_PHASE-1:0] PH_LAST    = '1;
  localparam logic [NB_PHASE-1:0] PH_ONE     = NB_PHASE'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_APPLY, S_LOCKED
  } state_t;

  state_t              r_state, w_state;
  logic [NB_PHASE-1:0] r_phase, w_phase;
  logic [NB_PHASE-1:0] r_best_phase, w_best_phase;
  logic [NB_ERR-1:0]   r_best_err, w_best_err;
  logic [NB_ERR-1:0]   r_err_acc, w_err_acc;
  logic [NB_ERR-1:0]   r_out_err, w_out_err;
  logic [NB_CNT-1:0]   r_cnt, w_cnt;
  logic                r_busy, w_busy;
  logic                r_lock, w_lock;
  logic                r_done, w_done;
  logic                w_sym;
  logic                w_restart;
  logic [NB_SUM-1:0]   w_err_sum;
  logic [NB_ERR-1:0]   w_acc_inc;

  assign w_sym     = i_valid & i_enable;
  assign w_err_sum = {1'b0, r_err_acc} + NB_SUM'(i_errI) + NB_SUM'(i_errQ);
  assign w_acc_inc = w_err_sum[NB_ERR] ? ERR_MAX : w_err_sum[NB_ERR-1:0];

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_best_phase = r_best_phase;
    w_best_err   = r_best_err;
    w_err_acc    = r_err_acc;
    w_out_err    = r_out_err;
    w_cnt        = r_cnt;
    w_busy       = r_busy;
    w_lock       = r_lock;
    w_done       = r_done;
    w_restart    = 1'b0;
    if (i_enable) begin
      w_done = 1'b0;
      case (r_state)
        S_IDLE: w_restart = i_start;
        S_SETTLE: begin
          if (r_cnt == '0) begin
            w_state = S_MEASURE;
            w_cnt   = CNT_WIN;
          end else if (w_sym) begin
            if (r_cnt == CNT_ONE) begin
              w_state = S_MEASURE;
              w_cnt   = CNT_WIN;
            end else begin
              w_cnt = r_cnt - CNT_ONE;
            end
          end
        end
        S_MEASURE: begin
          if (w_sym) begin
            w_err_acc = w_acc_inc;
            if (r_cnt == CNT_ONE) begin
              w_state = S_COMPARE;
              w_cnt   = '0;
            end else begin
              w_cnt = r_cnt - CNT_ONE;
            end
          end
        end
        S_COMPARE: begin
          // strict less-than: on a tie the earlier (lower) phase wins
          if (r_err_acc < r_best_err) begin
            w_best_err   = r_err_acc;
            w_best_phase = r_phase;
          end
          w_err_acc = '0;
          if (r_phase == PH_LAST) begin
            w_state = S_APPLY;
          end else begin
            w_phase = r_phase + PH_ONE;
            w_cnt   = CNT_SETTLE;
            w_state = S_SETTLE;
          end
        end
        S_APPLY: begin
          w_phase   = r_best_phase;
          w_out_err = r_best_err;
          w_lock    = (r_best_err <= LOCK_THR);
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_cnt     = CNT_WIN;
          w_err_acc = '0;
          w_state   = S_LOCKED;
        end
        S_LOCKED: begin
          if (i_start) begin
            w_restart = 1'b1;
          end else begin
`ifdef PHASE_SEARCH_TRACK_EN
            if (w_sym) begin
              if (r_cnt == CNT_ONE) begin
                if (w_acc_inc > LOCK_THR) begin
                  w_restart = 1'b1;
                end else begin
                  w_out_err = w_acc_inc;
                  w_err_acc = '0;
                  w_cnt     = CNT_WIN;
                end
              end else begin
                w_err_acc = w_acc_inc;
                w_cnt     = r_cnt - CNT_ONE;
              end
            end
`else
            w_state = S_LOCKED;
`endif
          end
        end
        default: w_state = S_IDLE;
      endcase
      if (w_restart) begin
        w_state      = S_SETTLE;
        w_phase      = '0;
        w_best_phase = '0;
        w_best_err   = ERR_MAX;
        w_out_err    = ERR_MAX;
        w_err_acc    = '0;
        w_cnt        = CNT_SETTLE;
        w_busy       = 1'b1;
        w_lock       = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_best_phase <= '0;
      r_best_err   <= ERR_MAX;
      r_err_acc    <= '0;
      r_out_err    <= ERR_MAX;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_lock       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_best_phase <= w_best_phase;
      r_best_err   <= w_best_err;
      r_err_acc    <= w_err_acc;
      r_out_err    <= w_out_err;
      r_cnt        <= w_cnt;
      r_busy       <= w_busy;
      r_lock       <= w_lock;
      r_done       <= w_done;
    end
  end

  assign o_phase    = r_phase;
  assign o_busy     = r_busy;
  assign o_lock     = r_lock;
  assign o_done     = r_done;
  assign o_best_err = r_out_err;

endmodule

// File: tb/tb_phase_search_ctrl.sv
// Directed bench for phase_search_ctrl: sweep results, tie-break, saturation, restart/reset,
// enable freeze and (with PHASE_SEARCH_TRACK_EN) loss-of-lock restart.
module tb_phase_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start, valid, errI, errQ;
  logic [1:0]  ph, ph4;
  logic        busy, lock, done, busy4, lock4, done4;
  logic [15:0] best;
  logic [3:0]  best4;

  phase_search_ctrl #(.NB_PHASE(2), .NB_ERR(16), .WIN_LEN(8), .SETTLE_SYM(2), .LOCK_MAX_ERR(0)) dut (
    .clock(clk), .i_reset(rst), .i_enable(en), .i_start(start), .i_valid(valid),
    .i_errI(errI), .i_errQ(errQ), .o_phase(ph), .o_busy(busy), .o_lock(lock),
    .o_done(done), .o_best_err(best));

  phase_search_ctrl #(.NB_PHASE(2), .NB_ERR(4), .WIN_LEN(8), .SETTLE_SYM(2), .LOCK_MAX_ERR(0)) dut4 (
    .clock(clk), .i_reset(rst), .i_enable(en), .i_start(start), .i_valid(valid),
    .i_errI(errI), .i_errQ(errQ), .o_phase(ph4), .o_busy(busy4), .o_lock(lock4),
    .o_done(done4), .o_best_err(best4));

  int checks = 0;
  int failures = 0;

  // symbol generator state: errors on measured symbols idx 2..(1+nerr[phase]) after each phase change
  int       nerr [4];
  bit       both = 0;
  bit       inj_once = 0;
  bit       start_req = 0;
  int       idx = 0;
  int       sym_cnt = 0;
  int       cyc = 0;
  logic [1:0] last_ph = 2'd0;

  // results captured at the done pulse
  int seq [8];
  int nseq, ndone, done_syms;
  logic [1:0]  res_ph, res_ph4;
  logic [15:0] res_best;
  logic [3:0]  res_best4;
  logic        res_lock, res_lock4, res_busy;

  initial begin
    valid = 0; errI = 0; errQ = 0; start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (ph !== last_ph) begin
        idx = 0;
        last_ph = ph;
      end
      if (start_req && (cyc % 4 == 2)) begin
        start = 1;
        start_req = 0;
        if (busy !== 1'b1 && en) begin
          idx = 0;
          sym_cnt = 0;
        end
      end
      valid = (cyc % 4 == 0);
      errI = 0;
      errQ = 0;
      if (valid && en) begin
        if ((idx >= 2 && idx < 2 + nerr[ph]) || inj_once) begin
          errI = 1;
          errQ = both;
          inj_once = 0;
        end
        idx++;
        sym_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    tick(2);
    rst = 0;
    tick(1);
  endtask

  task automatic req_start;
    start_req = 1;
    for (int i = 0; i < 8 && start_req; i++) tick(1);
  endtask

  task automatic set_err(input int e0, input int e1, input int e2, input int e3, input bit b);
    nerr[0] = e0; nerr[1] = e1; nerr[2] = e2; nerr[3] = e3;
    both = b;
  endtask

  task automatic wait_phase(input int p);
    int i;
    for (i = 0; i < 300 && ph !== 2'(p); i++) tick(1);
    chk("wait_phase", 32'(ph), 32'(p));
  endtask

  task automatic run_to_done;
    int after;
    bit seen;
    ndone = 0; nseq = 0; done_syms = -1; seen = 0; after = 0;
    for (int i = 0; i < 800 && after < 20; i++) begin
      tick(1);
      if (busy === 1'b1 && nseq < 8 && (nseq == 0 || seq[nseq-1] != int'(ph))) begin
        seq[nseq] = int'(ph);
        nseq++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (!seen) begin
          seen = 1;
          done_syms = sym_cnt;
          res_ph = ph; res_best = best; res_lock = lock; res_busy = busy;
          res_ph4 = ph4; res_best4 = best4; res_lock4 = lock4;
        end
      end
      if (seen) after++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 0; en = 1;
    set_err(0, 0, 0, 0, 0);
    tick(1);

    // reset and idle
    do_reset;
    chk("rst_phase", 32'(ph), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best", 32'(best), 32'h0000FFFF);
    tick(20);
    chk("idle_phase", 32'(ph), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_best", 32'(best), 32'h0000FFFF);
    en = 0;
    req_start;
    tick(4);
    chk("dis_start_busy", 32'(busy), 32'd0);
    en = 1;

    // clean phase 2 only, both branches erring elsewhere
    set_err(8, 8, 0, 8, 1);
    req_start;
    run_to_done;
    chk("sweep_nseq", 32'(nseq), 32'd4);
    for (int k = 0; k < 4; k++) chk("sweep_seq", 32'(seq[k]), 32'(k));
    chk("sweep_phase", 32'(res_ph), 32'd2);
    chk("sweep_best", 32'(res_best), 32'd0);
    chk("sweep_lock", 32'(res_lock), 32'd1);
    chk("sweep_busy", 32'(res_busy), 32'd0);
    chk("sweep_ndone", 32'(ndone), 32'd1);
    chk("sweep_syms", 32'(done_syms), 32'd40);

    // tie between phases 1 and 2
    do_reset;
    set_err(5, 3, 3, 7, 0);
    req_start;
    run_to_done;
    chk("tie_phase", 32'(res_ph), 32'd1);
    chk("tie_best", 32'(res_best), 32'd3);
    chk("tie_lock", 32'(res_lock), 32'd0);

    // saturation: 16 errors per window
    do_reset;
    set_err(8, 8, 8, 8, 1);
    req_start;
    run_to_done;
    chk("sat4_best", 32'(res_best4), 32'd15);
    chk("sat4_phase", 32'(res_ph4), 32'd0);
    chk("sat4_lock", 32'(res_lock4), 32'd0);
    chk("sat16_best", 32'(res_best), 32'd16);
    chk("sat16_phase", 32'(res_ph), 32'd0);

    // start while busy is ignored
    do_reset;
    set_err(8, 8, 0, 8, 1);
    req_start;
    wait_phase(1);
    tick(12);
    req_start;
    tick(1);
    chk("midstart_busy", 32'(busy), 32'd1);
    chk("midstart_phase", 32'(ph), 32'd1);
    run_to_done;
    chk("midstart_res_phase", 32'(res_ph), 32'd2);
    chk("midstart_res_best", 32'(res_best), 32'd0);
    chk("midstart_ndone", 32'(ndone), 32'd1);
    chk("midstart_syms", 32'(done_syms), 32'd40);

    // async reset during phase 2
    req_start;
    wait_phase(2);
    tick(3);
    rst = 1;
    #1;
    chk("abort_phase", 32'(ph), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_lock", 32'(lock), 32'd0);
    chk("abort_best", 32'(best), 32'h0000FFFF);
    tick(2);
    rst = 0;
    tick(1);
    req_start;
    tick(2);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_phase", 32'(ph), 32'd0);
    run_to_done;
    chk("restart_res_phase", 32'(res_ph), 32'd2);
    chk("restart_res_lock", 32'(res_lock), 32'd1);
    chk("restart_syms", 32'(done_syms), 32'd40);

    // enable freeze mid-measure
    do_reset;
    set_err(5, 3, 3, 7, 0);
    req_start;
    wait_phase(1);
    tick(14);
    en = 0;
    tick(50);
    chk("freeze_phase", 32'(ph), 32'd1);
    chk("freeze_busy", 32'(busy), 32'd1);
    en = 1;
    run_to_done;
    chk("freeze_res_phase", 32'(res_ph), 32'd1);
    chk("freeze_res_best", 32'(res_best), 32'd3);
    chk("freeze_res_lock", 32'(res_lock), 32'd0);
    chk("freeze_ndone", 32'(ndone), 32'd1);
    chk("freeze_syms", 32'(done_syms), 32'd40);

`ifdef PHASE_SEARCH_TRACK_EN
    // one error in a locked window restarts the search
    do_reset;
    set_err(8, 8, 0, 8, 1);
    req_start;
    run_to_done;
    chk("trk_lock", 32'(lock), 32'd1);
    inj_once = 1;
    for (int i = 0; i < 200 && lock === 1'b1; i++) tick(1);
    chk("trk_drop_lock", 32'(lock), 32'd0);
    chk("trk_drop_busy", 32'(busy), 32'd1);
    chk("trk_drop_phase", 32'(ph), 32'd0);
    run_to_done;
    chk("trk_res_phase", 32'(res_ph), 32'd2);
    chk("trk_res_lock", 32'(res_lock), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_search_ctrl.md
Name: phase_search_ctrl

Overview:
Sequencer that selects the RX sampling phase for the I/Q slicers automatically, replacing manual phase selection from the switches. It sweeps all phases, measures combined I+Q symbol errors over a fixed window at each phase, then applies the phase with the fewest errors and flags lock. It sits between the symbol-rate counter/BER error outputs and the slicer phase-select input.

Parameters:
NB_PHASE, 2, width of phase select; phases swept 0 .. 2**NB_PHASE-1
NB_ERR, 16, width of the error accumulator and best-error register
WIN_LEN, 1024, symbols measured per phase (>=1)
SETTLE_SYM, 16, symbols discarded after each phase change, for pipeline/PRBS flush (>=0)
LOCK_MAX_ERR, 0, maximum best-window error count that still asserts lock

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  global enable; low freezes the state, counters and outputs
i_start  in  1  single-cycle pulse: start or restart a search
i_valid  in  1  symbol strobe, one cycle per symbol
i_errI  in  1  I-branch symbol error; sampled only when i_valid=1
i_errQ  in  1  Q-branch symbol error; sampled only when i_valid=1
o_phase  out  NB_PHASE  phase select to the slicers
o_busy  out  1  search in progress
o_lock  out  1  search finished and best_err <= LOCK_MAX_ERR
o_done  out  1  one-cycle pulse when a search completes
o_best_err  out  NB_ERR  error count of the selected phase

Behaviour:
- Reset (async, i_reset=1): state IDLE, o_phase=0, o_busy=0, o_lock=0, o_done=0, o_best_err=all-ones, all internal counters=0.
- Symbol event = i_valid & i_enable. When i_enable=0, nothing advances, and an i_start pulse is ignored.
- States:
  - IDLE: i_start -> SETTLE. On entry, phase=0, best_err=all-ones, best_phase=0, o_busy=1, o_lock=0.
  - SETTLE: count symbol events; after SETTLE_SYM events -> MEASURE. With SETTLE_SYM=0, go to MEASURE on the next cycle.
  - MEASURE: on each symbol event, err_acc += i_errI + i_errQ (0..2), saturating at all-ones. After WIN_LEN events -> COMPARE.
  - COMPARE (1 cycle): if err_acc < best_err (strict), then best_err=err_acc and best_phase=phase. Ties keep the lower phase. err_acc is then cleared.
    - If phase is not the last phase: phase+1 -> SETTLE.
    - Otherwise -> APPLY.
  - APPLY (1 cycle): o_phase=best_phase, o_best_err=best_err, o_lock=(best_err<=LOCK_MAX_ERR), o_done=1, o_busy=0 -> LOCKED.
  - LOCKED: hold outputs. i_start -> same entry actions as from IDLE, then SETTLE.
- o_phase follows the swept phase during the search and is registered. It changes the cycle after COMPARE (or after the start pulse is accepted).
- i_start while busy is ignored; it has no effect mid-search.
- Symbol events arriving in COMPARE or APPLY are not counted.
- Reset mid-search aborts immediately to the reset values.
- Search duration = 2**NB_PHASE*(SETTLE_SYM+WIN_LEN) symbols + 2**NB_PHASE (COMPARE) + 1 (APPLY) cycles + symbol-alignment slack.

Optional Feature:
Macro PHASE_SEARCH_TRACK_EN.
- Defined: in LOCKED, the block keeps measuring consecutive WIN_LEN-symbol windows at o_phase (no settle).
  - If a window's error count exceeds LOCK_MAX_ERR: o_lock drops the next cycle and an automatic search restarts, as if i_start had been pulsed.
  - Otherwise o_best_err is updated with that window's count.
- Undefined: LOCKED is static; the error inputs are ignored outside the search.

Test Plan:
All scenarios use NB_PHASE=2, WIN_LEN=8, SETTLE_SYM=2, LOCK_MAX_ERR=0, i_valid every 4th cycle, i_enable=1.
- Reset then idle -> o_phase=0, o_busy=0, o_lock=0, o_best_err=16'hFFFF; no change without i_start.
- i_start; errors injected only when o_phase!=2 (I and Q both erring every symbol) -> o_phase sequence 0,1,2,3, then final o_phase=2, o_best_err=0, o_lock=1, exactly one o_done pulse, 40 symbols after start.
- Per-phase errors 5,3,3,7 (I only) -> o_phase=1 (tie resolves to lower phase), o_best_err=3, o_lock=0.
- Errors on all symbols, both branches, with NB_ERR=4 -> accumulator saturates at 15; o_best_err=15, o_phase=0, o_lock=0.
- Second i_start during MEASURE of phase 1 -> ignored; the search completes normally. i_reset pulse during phase 2 -> immediate reset values; a later i_start begins again at phase 0.
- i_enable=0 for 50 cycles mid-MEASURE -> counters and o_phase frozen; the result is identical to an uninterrupted run. With PHASE_SEARCH_TRACK_EN, one error in a LOCKED window -> o_lock=0 and o_busy=1 on the next cycle, and a new sweep starts.
